interrupt_priority_unit: RTL

Upstream stage of `Control_Unit` in the 8259 PIC, combining three functions: the Interrupt Request Register (IRR), the In-Service Register (ISR) and the priority resolver.
- Samples the eight IR lines, applies edge or level triggering and the OCW1 mask, and resolves priority (fully nested, with optional automatic rotation).
- Drives `INTERNAL_INT` and `IR_NUM` into `Control_Unit`.
- Tracks the INTA sequence and EOI commands to maintain ISR.

---
 rtl/interrupt_priority_unit_if.sv | 35 +++
 rtl/interrupt_priority_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/interrupt_priority_unit_if.sv
`default_nettype none
// =============================================================================
// Module      : interrupt_priority_unit_if
// Description : Request, acknowledge and EOI bundle between the 8259 front end
//               (IRR/ISR/priority) and its control logic.
// Revision    : 1.0 - initial release
// =============================================================================
interface interrupt_priority_unit_if #(
    parameter int NUM_IR = 8
);
    logic [NUM_IR-1:0] IR;
    logic              LEVEL;
    logic [NUM_IR-1:0] interrupt_mask;
    logic [1:0]        INTA_COUNT;
    logic              AEOI;
    logic              R;
    logic              EOI;
    logic              SEOI;
    logic [2:0]        SEOI_LEVEL;
    logic              INTERNAL_INT;
    logic [2:0]        IR_NUM;
    logic [NUM_IR-1:0] IRR;
    logic [NUM_IR-1:0] ISR;

    modport slave (
        input  IR, LEVEL, interrupt_mask, INTA_COUNT, AEOI, R, EOI, SEOI, SEOI_LEVEL,
        output INTERNAL_INT, IR_NUM, IRR, ISR
    );

    modport master (
        output IR, LEVEL, interrupt_mask, INTA_COUNT, AEOI, R, EOI, SEOI, SEOI_LEVEL,
        input  INTERNAL_INT, IR_NUM, IRR, ISR
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_priority_unit.sv
`default_nettype none
// =============================================================================
// Module      : interrupt_priority_unit
// Description : 8259 IRR, ISR and rotating priority resolver with INTA tracking.
// Revision    : 1.0 - initial release
// =============================================================================
module interrupt_priority_unit #(
    parameter int NUM_IR = 8
) (
    input  wire logic                  CLK,
    input  wire logic                  RESET,
    interrupt_priority_unit_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    localparam logic [NUM_IR-1:0] c_one = NUM_IR'(1);

    // Returns {valid, index} of the highest-priority set bit; lp is lowest priority.
    function automatic logic [3:0] find_first(input logic [NUM_IR-1:0] vec,
                                              input logic [2:0]        lp);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = NUM_IR; k >= 1; k--) begin
            idx = lp + 3'(k);
            if (vec[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [2:0] rank(input logic [2:0] idx, input logic [2:0] lp);
        return idx - lp - 3'd1;
    endfunction

    state_t            r_state, w_state_next;
    logic [NUM_IR-1:0] r_s1, r_s2, r_s2_d;
    logic [NUM_IR-1:0] r_irr, r_isr;
    logic [2:0]        r_lp;
    logic [2:0]        r_ir_num;
    logic              r_int;
    logic [1:0]        r_inta_prev;

    logic [3:0]        w_cand_f, w_cur_f;
    logic              w_cand_v, w_cur_v;
    logic [2:0]        w_cand, w_cur;
    logic              w_req;
    logic              w_first_ack, w_second_ack;
    logic              w_ack, w_aeoi, w_int_next;
    logic [NUM_IR-1:0] w_ack_set, w_eoi_clear, w_aeoi_clear, w_irr_next;

    assign w_cand_f = find_first(r_irr & ~bus.interrupt_mask, r_lp);
    assign w_cur_f  = find_first(r_isr, r_lp);
    assign w_cand_v = w_cand_f[3];
    assign w_cand   = w_cand_f[2:0];
    assign w_cur_v  = w_cur_f[3];
    assign w_cur    = w_cur_f[2:0];

    assign w_req = w_cand_v && (!w_cur_v || (rank(w_cand, r_lp) < rank(w_cur, r_lp)));

    assign w_first_ack  = (bus.INTA_COUNT == 2'd1) && (r_inta_prev != 2'd1);
    assign w_second_ack = (bus.INTA_COUNT == 2'd2) && (r_inta_prev != 2'd2);

    always_comb begin
        w_state_next = r_state;
        w_ack        = 1'b0;
        w_aeoi       = 1'b0;
        w_int_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_first_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = WAIT2;
                end else begin
                    w_int_next = w_req;
                end
            end
            WAIT2: begin
                if (w_second_ack) begin
                    w_aeoi       = bus.AEOI;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_ack_set    = (w_ack && w_cand_v) ? (c_one << w_cand) : '0;
    assign w_aeoi_clear = w_aeoi ? (c_one << r_ir_num) : '0;
    // A specific EOI overrides a simultaneous non-specific one.
    assign w_eoi_clear  = bus.SEOI             ? (c_one << bus.SEOI_LEVEL) :
                          (bus.EOI && w_cur_v) ? (c_one << w_cur)          : '0;

    // Edge mode latches rising edges until acknowledged; level mode tracks the line.
    assign w_irr_next = (bus.LEVEL ? r_s2 : (r_irr | (r_s2 & ~r_s2_d))) & ~w_ack_set;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_s2_d      <= '0;
            r_irr       <= '0;
            r_isr       <= '0;
            r_lp        <= 3'd7;
            r_ir_num    <= 3'd0;
            r_int       <= 1'b0;
            r_inta_prev <= 2'd0;
        end else begin
            r_s1        <= bus.IR;
            r_s2        <= r_s1;
            r_s2_d      <= r_s2;
            r_irr       <= w_irr_next;
            r_isr       <= (r_isr & ~w_eoi_clear & ~w_aeoi_clear) | w_ack_set;
            r_int       <= w_int_next;
            r_inta_prev <= bus.INTA_COUNT;
            if (w_ack) r_ir_num <= w_cand_v ? w_cand : 3'd7;
            // EOI-driven rotation takes precedence over automatic-EOI rotation.
            if (bus.SEOI) begin
                if (bus.R) r_lp <= bus.SEOI_LEVEL;
            end else if (bus.EOI && w_cur_v) begin
                if (bus.R) r_lp <= w_cur;
            end else if (w_aeoi && bus.R) begin
                r_lp <= r_ir_num;
            end
        end
    end

    assign bus.INTERNAL_INT = r_int;
    assign bus.IR_NUM       = r_ir_num;
    assign bus.IRR          = r_irr;
    assign bus.ISR          = r_isr;
endmodule
`default_nettype wire
